// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encodings,
// handshake levels and the core's register widths.
package div_seq_pkg;

    localparam int REG_DATA_WIDTH    = 32;
    localparam int DOUBLE_DATA_WIDTH = 2 * REG_DATA_WIDTH;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the result
// is produced one edge after the start instead of after the full loop.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = REG_DATA_WIDTH,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signed_div_in,
    input  logic [DATA_W-1:0]     dived_in,
    input  logic [DATA_W-1:0]     div_in,
    input  logic                  start_in,
    input  logic                  annul_in,
    output logic [2*DATA_W-1:0]   res_out,
    output logic                  rdy_out,
    output logic                  busy_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // {partial remainder, dividend/quotient}; the extra top bit of the
    // (DATA_W+1)-bit remainder is always 0 between steps, so it is only
    // materialised in the shifted trial value.
    logic [2*DATA_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dvs_neg_q, dvs_neg_d;
    logic [2*DATA_W-1:0]   res_q, res_d;
    logic                  rdy_q, rdy_d;

    logic                  dvd_neg, dvs_neg;
    logic [DATA_W-1:0]     abs_dvd, abs_dvs;
    logic [2*DATA_W:0]     shifted;
    logic [DATA_W:0]       trial;
    logic [DATA_W-1:0]     quot_fix, rem_fix;

    // Operand conditioning, one restoring step and final sign correction
    always_comb begin
        dvd_neg  = signed_div_in & dived_in[DATA_W-1];
        dvs_neg  = signed_div_in & div_in[DATA_W-1];
        abs_dvd  = dvd_neg ? -dived_in : dived_in;
        abs_dvs  = dvs_neg ? -div_in : div_in;
        shifted  = {work_q, 1'b0};
        trial    = shifted[2*DATA_W:DATA_W] - {1'b0, dvs_q};
        quot_fix = (dvd_neg_q ^ dvs_neg_q) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
        rem_fix  = dvd_neg_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
    end

    // Sequencing FSM: next state, datapath updates and registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        res_d     = res_q;
        rdy_d     = rdy_q;
        case (state_q)
            DIV_FREE: begin
                if (start_in == DIV_START && !annul_in) begin
                    if (div_in == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        dvs_d     = abs_dvs;
                        dvd_neg_d = dvd_neg;
                        dvs_neg_d = dvs_neg;
`ifdef DIV_EARLY_OUT_EN
                        // Preload the finished state: quotient 0, remainder |dividend|;
                        // the normal finalise step then restores the dividend sign.
                        if (abs_dvd < abs_dvs) begin
                            work_d = {abs_dvd, {DATA_W{1'b0}}};
                            cnt_d  = LAST_CNT;
                        end else begin
                            work_d = {{DATA_W{1'b0}}, abs_dvd};
                            cnt_d  = '0;
                        end
`else
                        work_d = {{DATA_W{1'b0}}, abs_dvd};
                        cnt_d  = '0;
`endif
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_in) begin
                    state_d = DIV_FREE;
                    res_d   = '0;
                    rdy_d   = DIV_RESULT_NOT_READY;
                end else begin
                    state_d = DIV_END;
                    res_d   = '0;
                    rdy_d   = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_in) begin
                    state_d = DIV_FREE;
                    res_d   = '0;
                    rdy_d   = DIV_RESULT_NOT_READY;
                end else if (cnt_q != LAST_CNT) begin
                    if (!trial[DATA_W]) begin
                        work_d = {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
                    end else begin
                        work_d = shifted[2*DATA_W-1:0];
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = DIV_END;
                    res_d   = {rem_fix, quot_fix};
                    rdy_d   = DIV_RESULT_READY;
                end
            end
            DIV_END: begin
                if (annul_in || start_in == DIV_STOP) begin
                    state_d = DIV_FREE;
                    res_d   = '0;
                    rdy_d   = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            res_q     <= '0;
            rdy_q     <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            res_q     <= res_d;
            rdy_q     <= rdy_d;
        end
    end

    // Outputs come straight from registers or the state decode
    always_comb begin
        res_out  = res_q;
        rdy_out  = rdy_q;
        busy_out = (state_q == DIV_BYZERO) || (state_q == DIV_ON);
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases with literal results plus
// randomized operations checked every cycle against an arithmetic model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           signed_div_in = 1'b0;
    logic [W-1:0]   dived_in = '0;
    logic [W-1:0]   div_in = '0;
    logic           start_in = 1'b0;
    logic           annul_in = 1'b0;
    logic [2*W-1:0] res_out;
    logic           rdy_out;
    logic           busy_out;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_res  = '0;
    logic           exp_rdy  = 1'b0;
    logic           exp_busy = 1'b0;

    div_seq #(.DATA_W(W), .CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .signed_div_in (signed_div_in),
        .dived_in      (dived_in),
        .div_in        (div_in),
        .start_in      (start_in),
        .annul_in      (annul_in),
        .res_out       (res_out),
        .rdy_out       (rdy_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic (truncating division)
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 0) return '0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Edges from acceptance until the result is visible
    function automatic int latency(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa, bb;
        aa = (s && a[31]) ? -a : a;
        bb = (s && b[31]) ? -b : b;
        if (b == 0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (aa < bb) return 1;
`else
        if (aa == bb && aa == 32'h0) return 1;
`endif
        return 33;
    endfunction

    // Per-cycle comparison of all outputs against the expected timeline
    always @(negedge clk) begin
        check("rdy_out", {63'b0, rdy_out}, {63'b0, exp_rdy});
        check("busy_out", {63'b0, busy_out}, {63'b0, exp_busy});
        check("res_out", res_out, exp_res);
    end

    // One DIV/DIVU transaction; annul_at>0 aborts before that edge
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int annul_at, input logic scramble,
                          input logic use_lit, input logic [63:0] lit);
        int lat;
        lat = latency(s, a, b);
        signed_div_in = s;
        dived_in      = a;
        div_in        = b;
        start_in      = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        exp_rdy  = 1'b0;
        exp_res  = '0;
        if (scramble) begin
            dived_in      = $urandom;
            div_in        = $urandom;
            signed_div_in = ~s;
        end
        for (int k = 1; k <= lat; k++) begin
            if (k == annul_at) annul_in = 1'b1;
            @(posedge clk); #1;
            if (k == annul_at) begin
                annul_in = 1'b0;
                start_in = 1'b0;
                exp_busy = 1'b0;
                exp_rdy  = 1'b0;
                exp_res  = '0;
                return;
            end
        end
        exp_busy = 1'b0;
        exp_rdy  = 1'b1;
        exp_res  = model(s, a, b);
        if (use_lit) check("literal_result", res_out, lit);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        @(posedge clk); #1;
        exp_rdy = 1'b0;
        exp_res = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 2, 0, 1'b0, 1'b1, {32'h2, 32'hE});
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1, 0, 1'b0, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 1'b0, 1'b1, {32'h1, 32'hFFFFFFFD});
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, {32'h0, 32'h80000000});
        run_op(1'b0, 32'h12345678, 32'h0, 1, 0, 1'b0, 1'b1, 64'h0);
        run_op(1'b0, 32'd1000, 32'd7, 0, 10, 1'b0, 1'b0, 64'h0);
        run_op(1'b0, 32'd9, 32'd3, 0, 0, 1'b0, 1'b1, {32'h0, 32'h3});
        run_op(1'b0, 32'd1000, 32'd7, 0, 0, 1'b1, 1'b1, {32'd6, 32'd142});
        run_op(1'b0, 32'd3, 32'd10, 0, 0, 1'b0, 1'b1, {32'h3, 32'h0});
        run_op(1'b1, 32'hFFFFFFFD, 32'd10, 0, 0, 1'b0, 1'b1, {32'hFFFFFFFD, 32'h0});

        // Asynchronous reset in the middle of the iteration loop
        signed_div_in = 1'b0;
        dived_in      = 32'd1000;
        div_in        = 32'd3;
        start_in      = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n    = 1'b0;
        exp_busy = 1'b0;
        #1;
        check("async_rst_busy", {63'b0, busy_out}, 64'h0);
        check("async_rst_rdy", {63'b0, rdy_out}, 64'h0);
        check("async_rst_res", res_out, 64'h0);
        start_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Start and annul together in idle must not launch
        start_in = 1'b1;
        annul_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        annul_in = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            logic        s;
            logic [31:0] a, b;
            int          mode, lat, ann;
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            mode = $urandom_range(0, 5);
            case (mode)
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       begin a = $urandom_range(0, 200); b = $urandom_range(201, 1000); end
                default: b = $urandom;
            endcase
            if (n == 0) begin
                s = 1'b1;
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            lat = latency(s, a, b);
            ann = ($urandom_range(0, 7) == 0 && lat > 1) ? $urandom_range(1, lat - 1) : 0;
            run_op(s, a, b, $urandom_range(0, 2), ann, 1'($urandom_range(0, 1)), 1'b0, 64'h0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
